// File: rtl/mult_iter.sv
// Iterative 32x32->64 multiplier, signed or unsigned: one multiplier bit
// retired per cycle through a 33-bit add and an accumulator right shift.
module mult_iter (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mult_begin,
  input  logic        mult_signed,
  input  logic [31:0] mult_op1,
  input  logic [31:0] mult_op2,
  output logic [63:0] product,
  output logic        mult_busy,
  output logic        mult_end
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_next;
  logic [31:0] mcand;
  logic [31:0] acc_hi;
  logic [31:0] acc_lo;
  logic [4:0]  count;
  logic        neg;

  logic [31:0] op1_mag, op2_mag;
  logic [32:0] sum;
  logic [63:0] acc_step;
  logic [63:0] result;

  // Magnitudes stay 32-bit unsigned, so 0x8000_0000 maps onto itself.
  always_comb begin
    op1_mag = (mult_signed && mult_op1[31]) ? (~mult_op1 + 32'd1) : mult_op1;
    op2_mag = (mult_signed && mult_op2[31]) ? (~mult_op2 + 32'd1) : mult_op2;
  end

  always_comb begin
    sum      = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? mcand : '0)};
    acc_step = {sum, acc_lo[31:1]};
    result   = neg ? (~acc_step + 64'd1) : acc_step;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mult_begin) state_next = RUN;
      RUN:     if (count == 5'd31) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mcand   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      count   <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mult_begin) begin
            mcand  <= op1_mag;
            acc_hi <= '0;
            acc_lo <= op2_mag;
            count  <= '0;
            neg    <= mult_signed & (mult_op1[31] ^ mult_op2[31]);
          end
        end
        RUN: begin
          {acc_hi, acc_lo} <= acc_step;
          count            <= count + 5'd1;
          // The result is taken from the post-final-iteration accumulator.
          if (count == 5'd31) product <= result;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mult_busy = (state == RUN) || (state == DONE);
    mult_end  = (state == DONE);
  end

endmodule
